// File: rtl/tone_generator.sv
// tone_generator: note index to square-wave buzzer drive at 50 MHz.
// Define TONE_SYNC_EN to add a 2-flop synchronizer and 2-cycle deglitch filter.
module tone_generator #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       noteIndex,
    output logic             buzzer,
    output logic             playing,
    output logic [CNT_W-1:0] curHalf
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [4:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_mid;
    logic [CNT_W-1:0] w_pend;

`ifdef TONE_SYNC_EN
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    // idx only follows a value seen identical on two consecutive clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_idx   <= '0;
        end else begin
            r_sync1 <= noteIndex;
            r_sync2 <= r_sync1;
            if (r_sync1 == r_sync2)
                r_idx <= r_sync2;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_idx <= '0;
        else
            r_idx <= noteIndex;
    end
`endif

    always_comb begin
        case (r_idx[2:0])
            3'd1:    w_mid = CNT_W'(95556);
            3'd2:    w_mid = CNT_W'(85131);
            3'd3:    w_mid = CNT_W'(75843);
            3'd4:    w_mid = CNT_W'(71586);
            3'd5:    w_mid = CNT_W'(63776);
            3'd6:    w_mid = CNT_W'(56818);
            3'd7:    w_mid = CNT_W'(50619);
            default: w_mid = '0;
        endcase
    end

    always_comb begin
        case (r_idx[4:3])
            2'b00:   w_pend = w_mid << 1;
            2'b01:   w_pend = w_mid;
            2'b11:   w_pend = w_mid >> 1;
            default: w_pend = '0;
        endcase
    end

    // new notes and rests are only applied at a half-period boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            buzzer  <= 1'b0;
            playing <= 1'b0;
            curHalf <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_pend != '0) begin
                        r_state <= RUN;
                        buzzer  <= 1'b1;
                        playing <= 1'b1;
                        curHalf <= w_pend;
                        r_cnt   <= w_pend - 1'b1;
                    end
                end
                RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_pend != '0) begin
                        buzzer  <= ~buzzer;
                        curHalf <= w_pend;
                        r_cnt   <= w_pend - 1'b1;
                    end else begin
                        r_state <= IDLE;
                        buzzer  <= 1'b0;
                        playing <= 1'b0;
                        curHalf <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: scoreboard bench for tone_generator.
// A phase-level model predicts every output change and the cycle it happens on.
module tb_tone_generator;

    localparam int CNT_W = 18;
`ifdef TONE_SYNC_EN
    localparam int LAT  = 4;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        int   t;
        logic p;
        logic b;
        int   h;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       noteIndex = '0;
    logic             buzzer;
    logic             playing;
    logic [CNT_W-1:0] curHalf;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   t_base = 0;
    rec_t exp_q[$];
    int   ev_t[$];
    int   ev_v[$];
    int   mid_tab[8] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619};

    logic             pp = 1'b0;
    logic             pb = 1'b0;
    logic [CNT_W-1:0] ph = '0;

    tone_generator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .noteIndex (noteIndex),
        .buzzer    (buzzer),
        .playing   (playing),
        .curHalf   (curHalf)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    // half-period in cycles for a note code, straight from the note table
    function automatic int half_of(input int v);
        int m;
        m = mid_tab[v % 8];
        case (v / 8)
            0:       return m * 2;
            1:       return m;
            3:       return m / 2;
            default: return 0;
        endcase
    endfunction

    // with the synchronizer, a value held for under 2 cycles never counts
    function automatic bit dropped(input int i);
        return SYNC && (i + 1 < ev_t.size()) && (ev_t[i+1] - ev_t[i] < 2);
    endfunction

    // note the design acts on at edge e
    function automatic int note_at(input int e);
        int v;
        v = 0;
        foreach (ev_t[i])
            if (ev_t[i] <= e - LAT && !dropped(i))
                v = ev_v[i];
        return v;
    endfunction

    function automatic int next_edge(input int e);
        int n;
        n = 32'h7fff_ffff;
        foreach (ev_t[i])
            if (!dropped(i) && ev_t[i] + LAT > e && ev_t[i] + LAT < n)
                n = ev_t[i] + LAT;
        return n;
    endfunction

    task automatic model(input int t_end);
        int   e;
        int   h;
        bit   run;
        logic lvl;
        e   = t_base + 1;
        run = 1'b0;
        lvl = 1'b0;
        while (e <= t_end) begin
            h = half_of(note_at(e));
            if (!run) begin
                if (h == 0) begin
                    e = next_edge(e);
                end else begin
                    run = 1'b1;
                    lvl = 1'b1;
                    exp_q.push_back('{e, 1'b1, lvl, h});
                    e = e + h;
                end
            end else if (h != 0) begin
                lvl = ~lvl;
                exp_q.push_back('{e, 1'b1, lvl, h});
                e = e + h;
            end else begin
                run = 1'b0;
                exp_q.push_back('{e, 1'b0, 1'b0, 0});
                e = e + 1;
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (buzzer !== 1'b0 || playing !== 1'b0 || curHalf !== '0) begin
            errors++;
            $display("FAIL %s: got b=%0b p=%0b h=%0d, need all zero",
                     name, buzzer, playing, curHalf);
        end
    endtask

    task automatic do_reset(input int v);
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        noteIndex = 5'(v);
        #1 check_idle("reset_now");
        repeat (3) @(posedge clk);
        #1 check_idle("reset_hold");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        exp_q.delete();
        ev_t.delete();
        ev_v.delete();
        t_base = cyc;
        ev_t.push_back(cyc);
        ev_v.push_back(v);
    endtask

    task automatic add_ev(input int t, input int v);
        ev_t.push_back(t);
        ev_v.push_back(v);
    endtask

    task automatic run_seg(input int t_end, input string name);
        model(t_end);
        for (int i = 1; i < ev_t.size(); i++) begin
            while (cyc < ev_t[i]) begin
                @(posedge clk);
                #1;
            end
            noteIndex = 5'(ev_v[i]);
        end
        while (cyc < t_end) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected changes never seen, first at t=%0d",
                     name, exp_q.size(), exp_q[0].t);
        end
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (!mon_en) begin
            pp = 1'b0;
            pb = 1'b0;
            ph = '0;
        end else if (playing !== pp || buzzer !== pb || curHalf !== ph) begin
            pp = playing;
            pb = buzzer;
            ph = curHalf;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: t=%0d p=%0b b=%0b h=%0d, none expected",
                         cyc, playing, buzzer, curHalf);
            end else begin
                r = exp_q.pop_front();
                if (r.t != cyc || r.p !== playing || r.b !== buzzer ||
                    r.h != int'(curHalf)) begin
                    errors++;
                    $display("FAIL edge_record: got t=%0d p=%0b b=%0b h=%0d, need t=%0d p=%0b b=%0b h=%0d",
                             cyc, playing, buzzer, curHalf, r.t, r.p, r.b, r.h);
                end
            end
        end
    end

    initial begin
        int s;
        int b;
        int t;

        // middle la: two full phases after release
        do_reset(5'b01110);
        run_seg(t_base + LAT + 2 * 56818 + 1, "la");

        // high C then low C, switch only at the boundary
        do_reset(5'b11001);
        s = t_base + LAT;
        add_ev(s + 100, 5'b00001);
        run_seg(s + 47778 + 191112 + 1, "octave");

        // rest mid-high phase: full phase, then idle on the boundary edge
        do_reset(5'b01101);
        s = t_base + LAT;
        add_ev(s + 1000, 0);
        run_seg(s + 63776 + 10, "rest");

        // reserved octave never sounds
        do_reset(5'b10011);
        run_seg(t_base + 30000, "reserved");
        checks++;
        if (buzzer !== 1'b0) begin
            errors++;
            $display("FAIL reserved_buzzer: got %0b, need 0", buzzer);
        end

        // reset 1000 cycles into a high phase, then a full restart
        do_reset(5'b01101);
        run_seg(t_base + LAT + 1000, "pre_reset");
        do_reset(5'b01101);
        run_seg(t_base + LAT + 63776 + 1, "restart");

        // single-cycle glitch landing on the sampling point of a boundary
        do_reset(5'b01011);
        b = t_base + LAT + 75843;
        add_ev(b - 2, 5'b01100);
        add_ev(b - 1, 5'b01011);
        run_seg(b + 1, "glitch");
        checks++;
        if (int'(curHalf) != (SYNC ? 75843 : 71586)) begin
            errors++;
            $display("FAIL glitch_half: got %0d, need %0d",
                     curHalf, SYNC ? 75843 : 71586);
        end

        // random note sequences, rests and reserved codes included
        for (int k = 0; k < 2; k++) begin
            do_reset(24 + $urandom_range(1, 7));
            t = t_base;
            for (int i = 0; i < 8; i++) begin
                t = t + $urandom_range(3, 30000);
                add_ev(t, $urandom_range(0, 31));
            end
            run_seg(t + 50000, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
